// File: rtl/ro_sweep_sequencer.sv
// Ring-oscillator sweep scheduler: clear, gate, settle, latch and transmit once per oscillator group.
// Optional `RO_TX_TIMEOUT_EN adds a sticky tx_timeout output and a bounded wait in SEND.
module ro_sweep_sequencer #(
    parameter int NUM_GROUPS    = 4,
    parameter int CLR_CYCLES    = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int TX_TIMEOUT    = 1024
) (
    input  logic        data_clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        continuous,
    input  logic        abort,
    input  logic [15:0] gate_len,
    input  logic        tx_done,
    output logic        count_clr,
    output logic        count_en,
    output logic        count_latch,
    output logic [1:0]  sel,
    output logic        tx_start,
`ifdef RO_TX_TIMEOUT_EN
    output logic        tx_timeout,
`endif
    output logic        busy,
    output logic        sweep_done,
    output logic [7:0]  sweep_count
);

    // One state-cycle counter serves every timed state, so it must hold both a gate length and the timeout.
    localparam int CW = ($clog2(TX_TIMEOUT + 1) > 16) ? $clog2(TX_TIMEOUT + 1) : 16;
    localparam logic [CW-1:0] CLR_LAST    = CW'(CLR_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [1:0]    SEL_LAST    = 2'(NUM_GROUPS - 1);

    typedef enum logic [2:0] {
        IDLE, CLEAR, GATE, SETTLE, LATCH, SEND, NEXT
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [15:0]     gate_len_q, gate_len_d;
    logic [1:0]      sel_q, sel_d;
    logic [7:0]      sweep_count_q, sweep_count_d;
    logic            sweep_done_q, sweep_done_d;
    logic            clr_q, clr_d, en_q, en_d, latch_q, latch_d;
    logic            tx_start_q, tx_start_d, busy_q, busy_d;
    logic [CW-1:0]   gate_last;
`ifdef RO_TX_TIMEOUT_EN
    localparam logic [CW-1:0] TO_LAST = CW'(TX_TIMEOUT - 1);
    logic            timeout_q, timeout_d;
`endif

    assign gate_last = (gate_len_q == 16'd0) ? '0 : CW'(gate_len_q - 16'd1);

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        gate_len_d    = gate_len_q;
        sweep_count_d = sweep_count_q;
        sweep_done_d  = 1'b0;
`ifdef RO_TX_TIMEOUT_EN
        timeout_d     = timeout_q;
`endif
        if (abort) begin
            state_d = IDLE;
            sel_d   = 2'd0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_d    = CLEAR;
                    gate_len_d = gate_len;
`ifdef RO_TX_TIMEOUT_EN
                    timeout_d  = 1'b0;
`endif
                end
                CLEAR:  if (cnt_q == CLR_LAST)    state_d = GATE;
                GATE:   if (cnt_q == gate_last)   state_d = SETTLE;
                SETTLE: if (cnt_q == SETTLE_LAST) state_d = LATCH;
                LATCH:  state_d = SEND;
                // The first SEND cycle carries tx_start, so a tx_done there cannot belong to this frame.
                SEND: if (tx_done && cnt_q != '0) begin
                    state_d = NEXT;
                    if (sel_q == SEL_LAST) begin
                        sweep_done_d  = 1'b1;
                        sweep_count_d = sweep_count_q + 8'd1;
                    end
                end
`ifdef RO_TX_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    state_d   = IDLE;
                    sel_d     = 2'd0;
                    timeout_d = 1'b1;
                end
`endif
                NEXT: if (sel_q != SEL_LAST) begin
                    sel_d   = sel_q + 2'd1;
                    state_d = CLEAR;
                end else begin
                    sel_d   = 2'd0;
                    state_d = continuous ? CLEAR : IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        cnt_d      = (state_d != state_q || state_d == IDLE) ? '0 : cnt_q + 1'b1;
        clr_d      = (state_d == CLEAR);
        en_d       = (state_d == GATE);
        latch_d    = (state_d == LATCH);
        tx_start_d = (state_d == SEND) && (state_q != SEND);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge data_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            gate_len_q    <= 16'd0;
            sel_q         <= 2'd0;
            sweep_count_q <= 8'd0;
            sweep_done_q  <= 1'b0;
            clr_q         <= 1'b0;
            en_q          <= 1'b0;
            latch_q       <= 1'b0;
            tx_start_q    <= 1'b0;
            busy_q        <= 1'b0;
`ifdef RO_TX_TIMEOUT_EN
            timeout_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            gate_len_q    <= gate_len_d;
            sel_q         <= sel_d;
            sweep_count_q <= sweep_count_d;
            sweep_done_q  <= sweep_done_d;
            clr_q         <= clr_d;
            en_q          <= en_d;
            latch_q       <= latch_d;
            tx_start_q    <= tx_start_d;
            busy_q        <= busy_d;
`ifdef RO_TX_TIMEOUT_EN
            timeout_q     <= timeout_d;
`endif
        end
    end

    assign count_clr   = clr_q;
    assign count_en    = en_q;
    assign count_latch = latch_q;
    assign sel         = sel_q;
    assign tx_start    = tx_start_q;
    assign busy        = busy_q;
    assign sweep_done  = sweep_done_q;
    assign sweep_count = sweep_count_q;
`ifdef RO_TX_TIMEOUT_EN
    assign tx_timeout  = timeout_q;
`endif

endmodule
